// File: rtl/dot_product_mac_if.sv
// Operand/result bundle between the HPS PIO exports and the dot-product engine.
// master: PIO side (drives operands, reads result); slave: the MAC engine.
interface dot_product_mac_if #(
    parameter int N = 8,
    parameter int W = 8
);
    localparam int OUT_W = 2*W + $clog2(N);

    logic [N*W-1:0]   a_bus;
    logic [N*W-1:0]   b_bus;
    logic             recompute;
    logic [OUT_W-1:0] dot_out;
    logic             busy;
    logic             done;

    modport master (
        output a_bus,
        output b_bus,
        output recompute,
        input  dot_out,
        input  busy,
        input  done
    );

    modport slave (
        input  a_bus,
        input  b_bus,
        input  recompute,
        output dot_out,
        output busy,
        output done
    );
endinterface

// File: rtl/dot_product_mac.sv
// Serial multiply-accumulate dot product of N W-bit lanes.
// Snapshots the operands on any change (or on recompute), then walks one lane
// per cycle. dot_out and a one-cycle done pulse appear N+1 cycles after the
// trigger. A new trigger mid-run restarts from lane 0 and discards the
// partial sum.
// Build option: define DOT_PRODUCT_MAC_SIGNED_EN for two's-complement operands
// and result; the default build is unsigned.
//
// state | meaning
// IDLE  | result held, waiting for an operand change or recompute
// RUN   | accumulating lane idx of the snapshot
module dot_product_mac #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic               clk_clk,
    input  logic               reset,
    dot_product_mac_if.slave   mac_if
);
    localparam int OUT_W = 2*W + $clog2(N);
    localparam int IDX_W = $clog2(N);
    localparam int P_W   = 2*W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N*W-1:0]     snap_a_q, snap_a_d;
    logic [N*W-1:0]     snap_b_q, snap_b_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   dot_q, dot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic               trigger;
    logic               last_lane;
    logic [W-1:0]       lane_a;
    logic [W-1:0]       lane_b;
    logic [OUT_W-1:0]   prod_ext;

    // Any difference from the snapshot, or an explicit request, restarts the run.
    assign trigger   = (mac_if.a_bus != snap_a_q) ||
                       (mac_if.b_bus != snap_b_q) ||
                       mac_if.recompute;
    assign last_lane = (idx_q == IDX_W'(N-1));
    assign lane_a    = snap_a_q[idx_q*W +: W];
    assign lane_b    = snap_b_q[idx_q*W +: W];

`ifdef DOT_PRODUCT_MAC_SIGNED_EN
    logic signed [P_W-1:0] prod_s;

    // Signed product, sign-extended so the accumulator adds in two's complement.
    assign prod_s   = $signed(lane_a) * $signed(lane_b);
    assign prod_ext = {{(OUT_W-P_W){prod_s[P_W-1]}}, prod_s};
`else
    logic [P_W-1:0] prod_u;

    // Unsigned product, zero-extended; N*(2^W-1)^2 always fits in OUT_W.
    assign prod_u   = lane_a * lane_b;
    assign prod_ext = {{(OUT_W-P_W){1'b0}}, prod_u};
`endif

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            snap_a_q <= '0;
            snap_b_q <= '0;
            acc_q    <= '0;
            dot_q    <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            acc_q    <= acc_d;
            dot_q    <= dot_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    // Next-state: trigger outranks the final-lane result update.
    always_comb begin
        state_d  = state_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        acc_d    = acc_q;
        dot_d    = dot_q;
        idx_d    = idx_q;
        done_d   = 1'b0;

        if (trigger) begin
            snap_a_d = mac_if.a_bus;
            snap_b_d = mac_if.b_bus;
            acc_d    = '0;
            idx_d    = '0;
            state_d  = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (last_lane) begin
                        dot_d   = acc_q + prod_ext;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q + prod_ext;
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign mac_if.dot_out = dot_q;
    assign mac_if.busy    = (state_q == RUN);
    assign mac_if.done    = done_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac: directed table, random vectors
// against a plain-arithmetic dot-product model, and hand-written sequences
// for mid-run restarts, recompute, back-to-back runs and reset mid-run.
module tb_dot_product_mac;
    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dot_product_mac_if #(.N(N), .W(W)) bus ();

    dot_product_mac #(.N(N), .W(W)) dut (
        .clk_clk (clk),
        .reset   (rst),
        .mac_if  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] cur_a = '0;
    logic [63:0] cur_b = '0;
    int          cur_dot = 0;

    int latency, busy_n, done_n, dot_at_done, early_upd;

    localparam logic [63:0] A18   = 64'h0807060504030201;
    localparam logic [63:0] B1    = 64'h0101010101010101;
    localparam logic [63:0] B1_B3 = 64'h0101010102010101;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: straight sum of lane products, reduced to 19 bits.
    function automatic int ref_dot(input logic [63:0] a, input logic [63:0] b);
        int s = 0;
        for (int i = 0; i < N; i++) begin
`ifdef DOT_PRODUCT_MAC_SIGNED_EN
            s += int'($signed(a[i*W +: W])) * int'($signed(b[i*W +: W]));
`else
            s += int'(a[i*W +: W]) * int'(b[i*W +: W]);
`endif
        end
        return s & 32'h7FFFF;
    endfunction

    // Drive new operands at a negedge; identical operands need a recompute pulse.
    task automatic start(input logic [63:0] a, input logic [63:0] b);
        bus.a_bus = a;
        bus.b_bus = b;
        if (a == cur_a && b == cur_b) bus.recompute = 1'b1;
        cur_a = a;
        cur_b = b;
    endtask

    // Watch ncyc cycles (sampled at negedge); optionally rewrite b at cycle change_at.
    task automatic observe(input int ncyc, input int prev_dot,
                           input int change_at, input logic [63:0] new_b);
        latency = 0; busy_n = 0; done_n = 0; dot_at_done = -1; early_upd = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) bus.recompute = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (latency == 0) begin
                    latency     = k;
                    dot_at_done = int'(bus.dot_out);
                end
            end else if (latency == 0 && int'(bus.dot_out) != prev_dot) begin
                early_upd++;
            end
            if (k == change_at) begin
                bus.b_bus = new_b;
                cur_b     = new_b;
            end
        end
    endtask

    task automatic run_check(input string name, input logic [63:0] a,
                             input logic [63:0] b, input int exp);
        start(a, b);
        observe(20, cur_dot, 0, '0);
        check({name, "_latency"}, latency, N+1);
        check({name, "_busy"}, busy_n, N);
        check({name, "_done"}, done_n, 1);
        check({name, "_dot"}, dot_at_done, exp);
        check({name, "_early"}, early_upd, 0);
        cur_dot = exp;
    endtask

    vec_t tbl[6];

    initial begin
        logic [63:0] ra, rb;
        int e;

        tbl[0] = '{a: A18, b: B1, exp: 36};
`ifdef DOT_PRODUCT_MAC_SIGNED_EN
        tbl[1] = '{a: 64'hFFFFFFFFFFFFFFFF, b: 64'hFFFFFFFFFFFFFFFF, exp: 8};
        tbl[5] = '{a: 64'h8080808080808080, b: 64'h7F7F7F7F7F7F7F7F, exp: 32'h60400};
`else
        tbl[1] = '{a: 64'hFFFFFFFFFFFFFFFF, b: 64'hFFFFFFFFFFFFFFFF, exp: 520200};
        tbl[5] = '{a: 64'h8080808080808080, b: 64'h7F7F7F7F7F7F7F7F, exp: 130048};
`endif
        tbl[2] = '{a: A18, b: 64'h0102030405060708, exp: 120};
        tbl[3] = '{a: 64'h0, b: 64'h0, exp: 0};
        tbl[4] = '{a: 64'h8080808080808080, b: 64'h8080808080808080, exp: 131072};

        bus.a_bus = '0;
        bus.b_bus = '0;
        bus.recompute = 1'b0;

        // Reset held three cycles, then idle with zero operands.
        repeat (3) @(negedge clk);
        check("rst_dot", int'(bus.dot_out), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        observe(20, 0, 0, '0);
        check("idle_busy", busy_n, 0);
        check("idle_done", done_n, 0);
        check("idle_dot", early_upd, 0);

        // Directed table.
        for (int i = 0; i < 6; i++)
            run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);

        // Random operands against the model.
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            e  = ref_dot(ra, rb);
            run_check($sformatf("rnd%0d", i), ra, rb, e);
        end

        // Change b_3 during the 4th RUN cycle, then during the final one.
        for (int c = 0; c < 2; c++) begin
            int ch;
            ch = (c == 0) ? 4 : N;
            run_check($sformatf("pre%0d", c), 64'h0, 64'h0, 0);
            start(A18, B1);
            observe(30, cur_dot, ch, B1_B3);
            check($sformatf("chg%0d_latency", c), latency, ch + N + 1);
            check($sformatf("chg%0d_busy", c), busy_n, ch + N);
            check($sformatf("chg%0d_done", c), done_n, 1);
            check($sformatf("chg%0d_dot", c), dot_at_done, 40);
            check($sformatf("chg%0d_early", c), early_upd, 0);
            cur_dot = 40;
        end

        // Recompute with unchanged operands.
        run_check("base36", A18, B1, 36);
        run_check("recompute", A18, B1, 36);

        // Back-to-back: new operands in the very cycle done is high.
        start(64'h0, 64'h0);
        observe(N+1, cur_dot, 0, '0);
        check("b2b_first_latency", latency, N+1);
        check("b2b_first_dot", dot_at_done, 0);
        cur_dot = 0;
        run_check("b2b_second", A18, B1, 36);

        // Reset mid-run: everything clears, no done from the aborted run.
        start(A18, B1);
        observe(4, cur_dot, 0, '0);
        check("midrst_pre_done", done_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dot", int'(bus.dot_out), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        rst = 1'b0;
        // Snapshot is now zero, so the held operands start a fresh run.
        cur_dot = 0;
        observe(20, 0, 0, '0);
        check("postrst_latency", latency, N+1);
        check("postrst_done", done_n, 1);
        check("postrst_dot", dot_at_done, 36);
        check("postrst_early", early_upd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
